// File: rtl/mac_vlg_tx_buf_if.sv
`default_nettype none
// mac_vlg_tx_buf_if: byte-stream bundle between the core (master) and the TX frame buffer (slave).
interface mac_vlg_tx_buf_if;
  logic [7:0] data_in;
  logic       valid_in;
  logic       error_in;
  logic [7:0] data_out;
  logic       valid_out;
  logic       error_out;
  logic       busy;

  modport master (
    output data_in, valid_in, error_in,
    input  data_out, valid_out, error_out, busy
  );

  modport slave (
    input  data_in, valid_in, error_in,
    output data_out, valid_out, error_out, busy
  );
endinterface
`default_nettype wire

// File: rtl/mac_vlg_tx_buf.sv
`default_nettype none
// mac_vlg_tx_buf: store-and-forward TX buffer releasing only complete, error-free frames.
// Build option: define MAC_VLG_TX_BUF_IFG_EN to stretch the inter-frame gap to IFG cycles.
module mac_vlg_tx_buf #(
  parameter int FIFO_DEPTH = 11,
  parameter int IFG        = 12
) (
  input  logic            clk,
  input  logic            rst,
  mac_vlg_tx_buf_if.slave tx
);
  localparam int AW = FIFO_DEPTH;
  localparam int PW = FIFO_DEPTH + 1;
`ifdef MAC_VLG_TX_BUF_IFG_EN
  localparam bit IFG_ON = 1'b1;
`else
  localparam bit IFG_ON = 1'b0;
`endif
  localparam int GAP_LEN = (IFG_ON && IFG > 1) ? IFG : 1;
  localparam int GAP_W   = (GAP_LEN > 1) ? $clog2(GAP_LEN) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PREP = 2'd1,
    S_SEND = 2'd2,
    S_GAP  = 2'd3
  } state_t;

  logic [8:0]       mem [2**AW];
  logic [7:0]       in_data_q;
  logic             in_vld_q, in_err_q, discard_q, error_q;
  logic [PW-1:0]    wr_ptr_q, wr_commit_q, rd_ptr_q, frame_cnt_q;
  logic [8:0]       ram_q;
  state_t           state_q, state_d;
  logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
  logic             rd_en, frame_dec;

  logic [PW-1:0]    used;
  logic             full, wr_last, wr_try, wr_drop, wr_en, commit;

  assign used    = wr_ptr_q - rd_ptr_q;
  assign full    = (used == {1'b1, {AW{1'b0}}});
  assign wr_last = in_vld_q & ~tx.valid_in;
  assign wr_try  = in_vld_q & ~discard_q;
  assign wr_drop = wr_try & (in_err_q | full);
  assign wr_en   = wr_try & ~(in_err_q | full);
  assign commit  = wr_en & wr_last;

  // A drop rewinds to the last committed frame and swallows the rest of the burst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_data_q   <= '0;
      in_vld_q    <= 1'b0;
      in_err_q    <= 1'b0;
      discard_q   <= 1'b0;
      error_q     <= 1'b0;
      wr_ptr_q    <= '0;
      wr_commit_q <= '0;
    end else begin
      in_data_q <= tx.data_in;
      in_vld_q  <= tx.valid_in;
      in_err_q  <= tx.error_in & tx.valid_in;
      error_q   <= wr_drop;
      discard_q <= discard_q ? (in_vld_q & tx.valid_in) : (wr_drop & ~wr_last);
      if (wr_drop) begin
        wr_ptr_q <= wr_commit_q;
      end else if (wr_en) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (commit) begin
        wr_commit_q <= wr_ptr_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr_q[AW-1:0]] <= {wr_last, in_data_q};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ram_q <= '0;
    end else if (rd_en) begin
      ram_q <= mem[rd_ptr_q[AW-1:0]];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      gap_cnt_q   <= '0;
      rd_ptr_q    <= '0;
      frame_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      gap_cnt_q <= gap_cnt_d;
      if (rd_en) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      case ({commit, frame_dec})
        2'b10:   frame_cnt_q <= frame_cnt_q + 1'b1;
        2'b01:   frame_cnt_q <= frame_cnt_q - 1'b1;
        default: frame_cnt_q <= frame_cnt_q;
      endcase
    end
  end

  // The final GAP cycle prefetches the next committed frame so the gap is exactly GAP_LEN.
  always_comb begin
    state_d   = state_q;
    gap_cnt_d = gap_cnt_q;
    rd_en     = 1'b0;
    frame_dec = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (frame_cnt_q != '0) begin
          state_d = S_PREP;
        end
      end
      S_PREP: begin
        rd_en   = 1'b1;
        state_d = S_SEND;
      end
      S_SEND: begin
        if (ram_q[8]) begin
          frame_dec = 1'b1;
          gap_cnt_d = GAP_W'(GAP_LEN - 1);
          state_d   = S_GAP;
        end else begin
          rd_en = 1'b1;
        end
      end
      S_GAP: begin
        if (gap_cnt_q == '0) begin
          if (frame_cnt_q != '0) begin
            rd_en   = 1'b1;
            state_d = S_SEND;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          gap_cnt_d = gap_cnt_q - 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign tx.valid_out = (state_q == S_SEND);
  assign tx.data_out  = (state_q == S_SEND) ? ram_q[7:0] : 8'h00;
  assign tx.error_out = error_q;
  assign tx.busy      = (state_q != S_IDLE);
endmodule
`default_nettype wire

// File: tb/tb_mac_vlg_tx_buf.sv
`default_nettype none
// tb_mac_vlg_tx_buf: directed frames against a queue model of released frames.
module tb_mac_vlg_tx_buf;
`ifdef MAC_VLG_TX_BUF_IFG_EN
  localparam int EXP_GAP = 12;
`else
  localparam int EXP_GAP = 1;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  mac_vlg_tx_buf_if bus ();

  mac_vlg_tx_buf #(.FIFO_DEPTH(6), .IFG(12)) dut (
    .clk (clk),
    .rst (rst),
    .tx  (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Model: bytes of every frame that must be released, in order, with a last flag.
  logic [8:0] exp_q[$];
  bit   in_frame = 0, have_prev = 0;
  int   low_run = 0, last_gap = -1, run_len = 0, last_run = 0;
  int   frames_out = 0, frames_started = 0, bytes_out = 0, err_pulses = 0;
  logic [7:0] first_data = 8'h00, last_data = 8'h00;

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      in_frame  = 0;
      have_prev = 0;
      low_run   = 0;
      run_len   = 0;
    end else begin
      if (bus.error_out) err_pulses++;
      if (bus.valid_out) begin
        if (!in_frame) begin
          if (have_prev) begin
            last_gap = low_run;
            check("ifg_min", 32'(low_run >= EXP_GAP), 32'd1);
          end
          in_frame = 1;
          run_len  = 0;
          first_data = bus.data_out;
          frames_started++;
        end
        run_len++;
        bytes_out++;
        check("byte_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          logic [8:0] e;
          e = exp_q.pop_front();
          check("data_out", 32'(bus.data_out), 32'(e[7:0]));
          if (e[8]) begin
            in_frame  = 0;
            have_prev = 1;
            low_run   = 0;
            last_run  = run_len;
            last_data = bus.data_out;
            frames_out++;
          end
        end
      end else begin
        check("valid_out_contig", 32'(bus.valid_out), 32'(in_frame));
        in_frame = 0;
        low_run++;
      end
    end
  end

  task automatic send_frame(input int len, input int seed, input int err_at, input bit good);
    for (int i = 0; i < len; i++) begin
      bus.data_in  = 8'(seed + i);
      bus.valid_in = 1'b1;
      bus.error_in = (i == err_at);
      if (good) exp_q.push_back({(i == len - 1), 8'(seed + i)});
      @(posedge clk); #1;
    end
    bus.data_in  = 8'h00;
    bus.valid_in = 1'b0;
    bus.error_in = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic wait_drain();
    int n = 0;
    repeat (4) @(posedge clk);
    #1;
    while ((exp_q.size() != 0 || bus.busy) && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain_timeout", 32'(n < 2000), 32'd1);
  endtask

  task automatic wait_start(input int target);
    int n = 0;
    while (frames_started < target && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    check("start_timeout", 32'(n < 300), 32'd1);
  endtask

  initial begin
    int b0, e0, f0, fs0;
    bus.data_in  = 8'h00;
    bus.valid_in = 1'b0;
    bus.error_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid_out", 32'(bus.valid_out), 32'd0);
    check("rst_data_out",  32'(bus.data_out),  32'd0);
    check("rst_error_out", 32'(bus.error_out), 32'd0);
    check("rst_busy",      32'(bus.busy),      32'd0);
    check("rst_frame_cnt", 32'(dut.frame_cnt_q), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // single 64-byte frame fills the 64-byte buffer exactly
    b0 = bytes_out; e0 = err_pulses;
    send_frame(64, 8'h00, -1, 1'b1);
    wait_drain();
    check("t1_bytes", 32'(bytes_out - b0), 32'd64);
    check("t1_run",   32'(last_run), 32'd64);
    check("t1_first", 32'(first_data), 32'h00);
    check("t1_last",  32'(last_data), 32'h3F);
    check("t1_err",   32'(err_pulses - e0), 32'd0);

    // back-to-back frames separated by one idle input cycle
    f0 = frames_out;
    send_frame(60, 8'h40, -1, 1'b1);
    send_frame(60, 8'h80, -1, 1'b1);
    wait_drain();
    check("t2_frames", 32'(frames_out - f0), 32'd2);
    check("t2_gap",    32'(last_gap), 32'(EXP_GAP));

    // error on byte 10 of A, then good frame B
    b0 = bytes_out; e0 = err_pulses; f0 = frames_out;
    send_frame(100, 8'h10, 10, 1'b0);
    send_frame(50, 8'hA0, -1, 1'b1);
    wait_drain();
    check("t3_err",       32'(err_pulses - e0), 32'd1);
    check("t3_bytes",     32'(bytes_out - b0), 32'd50);
    check("t3_run",       32'(last_run), 32'd50);
    check("t3_frames",    32'(frames_out - f0), 32'd1);
    check("t3_frame_cnt", 32'(dut.frame_cnt_q), 32'd0);

    // 80-byte frame overflows; a following 64-byte frame fits exactly
    b0 = bytes_out; e0 = err_pulses;
    send_frame(80, 8'h20, -1, 1'b0);
    repeat (8) @(posedge clk);
    #1;
    check("t4_drop_err",   32'(err_pulses - e0), 32'd1);
    check("t4_drop_bytes", 32'(bytes_out - b0), 32'd0);
    send_frame(64, 8'h55, -1, 1'b1);
    wait_drain();
    check("t4_err",   32'(err_pulses - e0), 32'd1);
    check("t4_bytes", 32'(bytes_out - b0), 32'd64);
    check("t4_run",   32'(last_run), 32'd64);

    // 20 frames of 40 bytes wrap the pointers many times
    b0 = bytes_out; f0 = frames_out; fs0 = frames_started; e0 = err_pulses;
    for (int i = 0; i < 20; i++) begin
      send_frame(40, i, -1, 1'b1);
      wait_start(fs0 + i + 1);
    end
    wait_drain();
    check("t5_frames", 32'(frames_out - f0), 32'd20);
    check("t5_bytes",  32'(bytes_out - b0), 32'd800);
    check("t5_err",    32'(err_pulses - e0), 32'd0);

    // reset during SEND, then a single-byte frame
    fs0 = frames_started;
    send_frame(60, 8'h33, -1, 1'b1);
    wait_start(fs0 + 1);
    repeat (10) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("t6_rst_valid", 32'(bus.valid_out), 32'd0);
    check("t6_rst_busy",  32'(bus.busy), 32'd0);
    check("t6_rst_data",  32'(bus.data_out), 32'd0);
    @(posedge clk); @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    f0 = frames_out;
    send_frame(1, 8'hC3, -1, 1'b1);
    wait_drain();
    check("t6_frames", 32'(frames_out - f0), 32'd1);
    check("t6_run",    32'(last_run), 32'd1);
    check("t6_data",   32'(first_data), 32'hC3);

    check("model_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_checks);
    $fatal(1, "watchdog");
  end
endmodule
`default_nettype wire
